// File: rtl/axi4_to_tl_pkg.sv
// Bridge-local state encoding for the AXI4 -> TileLink bridge.
package axi4_to_tl_pkg;

  typedef enum logic [2:0] {
    IDLE, RD_A, RD_D, WR_A, WR_D, ERR_R, ERR_W, ERR_B
  } state_e;

endpackage

// File: rtl/axi_pkg.sv
// AXI4 channel payloads and response/burst encodings shared by AXI-facing blocks.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } aw_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;

endpackage

// File: rtl/tl_pkg.sv
// TileLink A/D channel payloads, A opcodes and the byte-mask helper for Get requests.
package tl_pkg;

  localparam logic [2:0] PUT_FULL_DATA    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL_DATA = 3'd1;
  localparam logic [2:0] GET              = 3'd4;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [7:0]  size;
    logic [3:0]  source;
    logic [31:0] address;
    logic [7:0]  mask;
    logic [63:0] data;
    logic        corrupt;
  } A_chan_bits_t;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  param;
    logic [7:0]  size;
    logic [3:0]  source;
    logic        sink;
    logic        denied;
    logic [63:0] data;
    logic        corrupt;
  } D_chan_bits_t;

  // Byte lanes touched by one beat of the given AXI size inside a 64-bit word.
  function automatic logic [7:0] get_mask(input logic [2:0] addr, input logic [2:0] size);
    logic [7:0] m;
    case (size)
      3'd0:    m = 8'b0000_0001 << addr;
      3'd1:    m = 8'b0000_0011 << {addr[2:1], 1'b0};
      3'd2:    m = addr[2] ? 8'hf0 : 8'h0f;
      default: m = 8'hff;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/axi4_to_tl.sv
// AXI4 slave to TileLink master bridge, one transaction in flight; bad bursts are answered locally.
module axi4_to_tl
  import axi_pkg::*;
  import tl_pkg::*;
  import axi4_to_tl_pkg::*;
#(
  parameter logic [3:0] TL_SOURCE = 4'd0,
  parameter int         MAX_BEATS = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 AXI_AW_valid_i,
  output logic                 AXI_AW_ready_o,
  input  axi_pkg::aw_chan_t    AXI_AW_bits_i,
  input  logic                 AXI_W_valid_i,
  output logic                 AXI_W_ready_o,
  input  axi_pkg::w_chan_t     AXI_W_bits_i,
  output logic                 AXI_B_valid_o,
  input  logic                 AXI_B_ready_i,
  output axi_pkg::b_chan_t     AXI_B_bits_o,
  input  logic                 AXI_AR_valid_i,
  output logic                 AXI_AR_ready_o,
  input  axi_pkg::ar_chan_t    AXI_AR_bits_i,
  output logic                 AXI_R_valid_o,
  input  logic                 AXI_R_ready_i,
  output axi_pkg::r_chan_t     AXI_R_bits_o,
  output logic                 TL_A_valid_o,
  input  logic                 TL_A_ready_i,
  output tl_pkg::A_chan_bits_t TL_A_bits_o,
  input  logic                 TL_D_valid_i,
  output logic                 TL_D_ready_o,
  input  tl_pkg::D_chan_bits_t TL_D_bits_i
);

  state_e      state_q, state_d;
  logic [3:0]  id_q;
  logic [31:0] addr_q;
  logic [7:0]  len_q;
  logic [2:0]  size_q;
  logic [7:0]  cnt_q;
  logic        werr_q;
  logic        rr_q;

  logic ar_hs, aw_hs, cnt_inc, werr_set, last_beat, ar_bad, aw_bad;
  logic unused_d;

  assign last_beat = (cnt_q == len_q);
  assign ar_bad = (AXI_AR_bits_i.burst == BURST_WRAP) ||
                  (({1'b0, AXI_AR_bits_i.len} + 9'd1) > 9'(MAX_BEATS));
  assign aw_bad = (AXI_AW_bits_i.burst == BURST_WRAP) ||
                  (({1'b0, AXI_AW_bits_i.len} + 9'd1) > 9'(MAX_BEATS));
  assign unused_d = ^{TL_D_bits_i.opcode, TL_D_bits_i.param, TL_D_bits_i.size,
                      TL_D_bits_i.source, TL_D_bits_i.sink};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Request fields are captured once at the address handshake and held for the whole burst.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      id_q   <= '0;
      addr_q <= '0;
      len_q  <= '0;
      size_q <= '0;
      cnt_q  <= '0;
      werr_q <= 1'b0;
      rr_q   <= 1'b0;
    end else begin
      if (ar_hs) begin
        id_q   <= AXI_AR_bits_i.id;
        addr_q <= AXI_AR_bits_i.addr;
        len_q  <= AXI_AR_bits_i.len;
        size_q <= AXI_AR_bits_i.size;
      end else if (aw_hs) begin
        id_q   <= AXI_AW_bits_i.id;
        addr_q <= AXI_AW_bits_i.addr;
        len_q  <= AXI_AW_bits_i.len;
        size_q <= AXI_AW_bits_i.size;
      end
      if (ar_hs || aw_hs) begin
        cnt_q  <= '0;
        werr_q <= 1'b0;
        rr_q   <= ~rr_q;
      end else begin
        if (cnt_inc)  cnt_q  <= cnt_q + 8'd1;
        if (werr_set) werr_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    ar_hs          = 1'b0;
    aw_hs          = 1'b0;
    cnt_inc        = 1'b0;
    werr_set       = 1'b0;
    AXI_AW_ready_o = 1'b0;
    AXI_AR_ready_o = 1'b0;
    AXI_W_ready_o  = 1'b0;
    AXI_B_valid_o  = 1'b0;
    AXI_R_valid_o  = 1'b0;
    TL_A_valid_o   = 1'b0;
    TL_D_ready_o   = 1'b0;

    AXI_B_bits_o.id   = id_q;
    AXI_B_bits_o.resp = RESP_OKAY;
    AXI_R_bits_o.id   = id_q;
    AXI_R_bits_o.data = '0;
    AXI_R_bits_o.resp = RESP_OKAY;
    AXI_R_bits_o.last = last_beat;

    TL_A_bits_o.opcode  = GET;
    TL_A_bits_o.param   = '0;
    TL_A_bits_o.size    = len_q;
    TL_A_bits_o.source  = TL_SOURCE;
    TL_A_bits_o.address = addr_q;
    TL_A_bits_o.mask    = get_mask(addr_q[2:0], size_q);
    TL_A_bits_o.data    = '0;
    TL_A_bits_o.corrupt = 1'b0;

    case (state_q)
      // rr_q low favours the read channel when both address channels are valid.
      IDLE: begin
        AXI_AR_ready_o = AXI_AR_valid_i && (!AXI_AW_valid_i || rr_q == 1'b0);
        AXI_AW_ready_o = AXI_AW_valid_i && !AXI_AR_ready_o;
        ar_hs = AXI_AR_ready_o;
        aw_hs = AXI_AW_ready_o;
        if (ar_hs)      state_d = ar_bad ? ERR_R : RD_A;
        else if (aw_hs) state_d = aw_bad ? ERR_W : WR_A;
      end
      RD_A: begin
        TL_A_valid_o = 1'b1;
        if (TL_A_ready_i) state_d = RD_D;
      end
      RD_D: begin
        AXI_R_valid_o     = TL_D_valid_i;
        TL_D_ready_o      = AXI_R_ready_i;
        AXI_R_bits_o.data = TL_D_bits_i.data;
        if (TL_D_bits_i.denied)       AXI_R_bits_o.resp = RESP_DECERR;
        else if (TL_D_bits_i.corrupt) AXI_R_bits_o.resp = RESP_SLVERR;
        if (TL_D_valid_i && AXI_R_ready_i) begin
          cnt_inc = 1'b1;
          if (last_beat) state_d = IDLE;
        end
      end
      // The beat counter alone ends the burst; a misplaced W.last only poisons the response.
      WR_A: begin
        TL_A_valid_o        = AXI_W_valid_i;
        AXI_W_ready_o       = TL_A_ready_i;
        TL_A_bits_o.data    = AXI_W_bits_i.data;
        TL_A_bits_o.mask    = AXI_W_bits_i.strb;
        TL_A_bits_o.opcode  = (len_q == 8'd0 && AXI_W_bits_i.strb == 8'hff) ?
                              PUT_FULL_DATA : PUT_PARTIAL_DATA;
        if (AXI_W_valid_i && TL_A_ready_i) begin
          cnt_inc  = 1'b1;
          werr_set = (AXI_W_bits_i.last != last_beat);
          if (last_beat) state_d = WR_D;
        end
      end
      WR_D: begin
        AXI_B_valid_o = TL_D_valid_i;
        TL_D_ready_o  = AXI_B_ready_i;
        if (werr_q || TL_D_bits_i.corrupt) AXI_B_bits_o.resp = RESP_SLVERR;
        else if (TL_D_bits_i.denied)       AXI_B_bits_o.resp = RESP_DECERR;
        if (TL_D_valid_i && AXI_B_ready_i) state_d = IDLE;
      end
      ERR_W: begin
        AXI_W_ready_o = 1'b1;
        if (AXI_W_valid_i) begin
          cnt_inc = 1'b1;
          if (last_beat) state_d = ERR_B;
        end
      end
      ERR_B: begin
        AXI_B_valid_o     = 1'b1;
        AXI_B_bits_o.resp = RESP_SLVERR;
        if (AXI_B_ready_i) state_d = IDLE;
      end
      ERR_R: begin
        AXI_R_valid_o     = 1'b1;
        AXI_R_bits_o.resp = RESP_SLVERR;
        if (AXI_R_ready_i) begin
          cnt_inc = 1'b1;
          if (last_beat) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi4_to_tl.sv
// Scoreboard bench for axi4_to_tl: queued AXI/TL drivers, expected-response queues, negedge monitor.
module tb_axi4_to_tl;
  import axi_pkg::*;
  import tl_pkg::*;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              AXI_AW_valid_i, AXI_AW_ready_o;
  aw_chan_t          AXI_AW_bits_i;
  logic              AXI_W_valid_i, AXI_W_ready_o;
  w_chan_t           AXI_W_bits_i;
  logic              AXI_B_valid_o, AXI_B_ready_i;
  b_chan_t           AXI_B_bits_o;
  logic              AXI_AR_valid_i, AXI_AR_ready_o;
  ar_chan_t          AXI_AR_bits_i;
  logic              AXI_R_valid_o, AXI_R_ready_i;
  r_chan_t           AXI_R_bits_o;
  logic              TL_A_valid_o, TL_A_ready_i;
  A_chan_bits_t      TL_A_bits_o;
  logic              TL_D_valid_i, TL_D_ready_o;
  D_chan_bits_t      TL_D_bits_i;

  axi4_to_tl #(.TL_SOURCE(4'd0), .MAX_BEATS(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .AXI_AW_valid_i(AXI_AW_valid_i), .AXI_AW_ready_o(AXI_AW_ready_o), .AXI_AW_bits_i(AXI_AW_bits_i),
    .AXI_W_valid_i(AXI_W_valid_i),   .AXI_W_ready_o(AXI_W_ready_o),   .AXI_W_bits_i(AXI_W_bits_i),
    .AXI_B_valid_o(AXI_B_valid_o),   .AXI_B_ready_i(AXI_B_ready_i),   .AXI_B_bits_o(AXI_B_bits_o),
    .AXI_AR_valid_i(AXI_AR_valid_i), .AXI_AR_ready_o(AXI_AR_ready_o), .AXI_AR_bits_i(AXI_AR_bits_i),
    .AXI_R_valid_o(AXI_R_valid_o),   .AXI_R_ready_i(AXI_R_ready_i),   .AXI_R_bits_o(AXI_R_bits_o),
    .TL_A_valid_o(TL_A_valid_o),     .TL_A_ready_i(TL_A_ready_i),     .TL_A_bits_o(TL_A_bits_o),
    .TL_D_valid_i(TL_D_valid_i),     .TL_D_ready_o(TL_D_ready_o),     .TL_D_bits_i(TL_D_bits_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  aw_chan_t     aw_q[$];
  ar_chan_t     ar_q[$];
  w_chan_t      w_q[$];
  D_chan_bits_t d_q[$];
  A_chan_bits_t exp_a_q[$];
  r_chan_t      exp_r_q[$];
  b_chan_t      exp_b_q[$];

  logic r_toggle   = 1'b0;
  logic chk_mirror = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic push_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    ar_chan_t c;
    c.id = id; c.addr = addr; c.len = len; c.size = size; c.burst = burst;
    ar_q.push_back(c);
  endtask

  task automatic push_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    aw_chan_t c;
    c.id = id; c.addr = addr; c.len = len; c.size = size; c.burst = burst;
    aw_q.push_back(c);
  endtask

  task automatic push_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
    w_chan_t c;
    c.data = data; c.strb = strb; c.last = last;
    w_q.push_back(c);
  endtask

  task automatic push_d(input logic [63:0] data, input logic denied, input logic corrupt);
    D_chan_bits_t c;
    c = '0;
    c.data = data; c.denied = denied; c.corrupt = corrupt;
    d_q.push_back(c);
  endtask

  task automatic exp_a(input logic [2:0] opcode, input logic [7:0] size, input logic [31:0] addr,
                       input logic [7:0] mask, input logic [63:0] data);
    A_chan_bits_t c;
    c = '0;
    c.opcode = opcode; c.size = size; c.source = 4'd0; c.address = addr; c.mask = mask; c.data = data;
    exp_a_q.push_back(c);
  endtask

  task automatic exp_r(input logic [3:0] id, input logic [63:0] data, input logic [1:0] resp, input logic last);
    r_chan_t c;
    c.id = id; c.data = data; c.resp = resp; c.last = last;
    exp_r_q.push_back(c);
  endtask

  task automatic exp_b(input logic [3:0] id, input logic [1:0] resp);
    b_chan_t c;
    c.id = id; c.resp = resp;
    exp_b_q.push_back(c);
  endtask

  // Drivers: sample handshakes on the falling edge, advance queues just after the rising edge.
  initial begin
    logic ar_fire, aw_fire, w_fire, d_fire;
    AXI_AW_valid_i = 1'b0; AXI_AW_bits_i = '0;
    AXI_AR_valid_i = 1'b0; AXI_AR_bits_i = '0;
    AXI_W_valid_i  = 1'b0; AXI_W_bits_i  = '0;
    TL_D_valid_i   = 1'b0; TL_D_bits_i   = '0;
    AXI_R_ready_i  = 1'b1; AXI_B_ready_i = 1'b1; TL_A_ready_i = 1'b1;
    forever begin
      @(negedge clk_i);
      ar_fire = !rst_i && AXI_AR_valid_i && AXI_AR_ready_o;
      aw_fire = !rst_i && AXI_AW_valid_i && AXI_AW_ready_o;
      w_fire  = !rst_i && AXI_W_valid_i && AXI_W_ready_o;
      d_fire  = !rst_i && TL_D_valid_i && TL_D_ready_o;
      @(posedge clk_i);
      #1;
      if (ar_fire && ar_q.size() > 0) void'(ar_q.pop_front());
      if (aw_fire && aw_q.size() > 0) void'(aw_q.pop_front());
      if (w_fire && w_q.size() > 0)   void'(w_q.pop_front());
      if (d_fire && d_q.size() > 0)   void'(d_q.pop_front());
      AXI_AR_valid_i = (ar_q.size() > 0);
      if (ar_q.size() > 0) AXI_AR_bits_i = ar_q[0];
      AXI_AW_valid_i = (aw_q.size() > 0);
      if (aw_q.size() > 0) AXI_AW_bits_i = aw_q[0];
      AXI_W_valid_i = (w_q.size() > 0);
      if (w_q.size() > 0) AXI_W_bits_i = w_q[0];
      TL_D_valid_i = (d_q.size() > 0);
      if (d_q.size() > 0) TL_D_bits_i = d_q[0];
      if (r_toggle) AXI_R_ready_i = ~AXI_R_ready_i;
    end
  end

  // Monitor: every completed output handshake is compared against the head of its expected queue.
  always @(negedge clk_i) begin
    A_chan_bits_t ea;
    r_chan_t      er;
    b_chan_t      eb;
    if (!rst_i) begin
      if (TL_A_valid_o && TL_A_ready_i) begin
        if (exp_a_q.size() == 0) checkOutput("a_unexpected", 64'd1, 64'd0);
        else begin
          ea = exp_a_q.pop_front();
          checkOutput("a_ctrl", {TL_A_bits_o.opcode, TL_A_bits_o.size, TL_A_bits_o.source, TL_A_bits_o.mask},
                      {ea.opcode, ea.size, ea.source, ea.mask});
          checkOutput("a_addr", TL_A_bits_o.address, ea.address);
          if (ea.opcode != GET) checkOutput("a_data", TL_A_bits_o.data, ea.data);
        end
      end
      if (AXI_R_valid_o && AXI_R_ready_i) begin
        if (exp_r_q.size() == 0) checkOutput("r_unexpected", 64'd1, 64'd0);
        else begin
          er = exp_r_q.pop_front();
          checkOutput("r_data", AXI_R_bits_o.data, er.data);
          checkOutput("r_id_resp_last", {AXI_R_bits_o.id, AXI_R_bits_o.resp, AXI_R_bits_o.last},
                      {er.id, er.resp, er.last});
        end
      end
      if (AXI_B_valid_o && AXI_B_ready_i) begin
        if (exp_b_q.size() == 0) checkOutput("b_unexpected", 64'd1, 64'd0);
        else begin
          eb = exp_b_q.pop_front();
          checkOutput("b_id_resp", {AXI_B_bits_o.id, AXI_B_bits_o.resp}, {eb.id, eb.resp});
        end
      end
      if (chk_mirror && AXI_R_valid_o) checkOutput("d_ready_mirror", TL_D_ready_o, AXI_R_ready_i);
    end
  end

  task automatic wait_idle(input string name);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk_i);
      done = (ar_q.size() == 0) && (aw_q.size() == 0) && (w_q.size() == 0) && (d_q.size() == 0) &&
             (exp_a_q.size() == 0) && (exp_r_q.size() == 0) && (exp_b_q.size() == 0);
    end
    if (!done) begin
      checkOutput({name, "_timeout"}, 64'd1, 64'd0);
      ar_q.delete(); aw_q.delete(); w_q.delete(); d_q.delete();
      exp_a_q.delete(); exp_r_q.delete(); exp_b_q.delete();
    end
    repeat (4) @(negedge clk_i);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    checkOutput("reset_outputs",
                {AXI_AW_ready_o, AXI_AR_ready_o, AXI_W_ready_o, AXI_B_valid_o, AXI_R_valid_o, TL_A_valid_o, TL_D_ready_o},
                64'd0);
    rst_i = 1'b0;
  endtask

  task automatic applyStimulus(input int test);
    case (test)
      1: begin
        exp_a(GET, 8'd0, 32'h8000_0010, 8'hff, 64'd0);
        push_d(64'h1122334455667788, 1'b0, 1'b0);
        exp_r(4'd3, 64'h1122334455667788, RESP_OKAY, 1'b1);
        push_ar(4'd3, 32'h8000_0010, 8'd0, 3'd3, BURST_INCR);
        wait_idle("t1_read");
        exp_a(GET, 8'd0, 32'h8000_0014, 8'hf0, 64'd0);
        push_d(64'h0000_0000_CAFE_F00D, 1'b0, 1'b0);
        exp_r(4'd4, 64'h0000_0000_CAFE_F00D, RESP_OKAY, 1'b1);
        push_ar(4'd4, 32'h8000_0014, 8'd0, 3'd2, BURST_INCR);
        wait_idle("t1_read_size2");
      end
      2: begin
        chk_mirror = 1'b1;
        r_toggle = 1'b1;
        exp_a(GET, 8'd3, 32'h8000_0100, 8'hff, 64'd0);
        push_d(64'hA0, 1'b0, 1'b0);
        push_d(64'hA1, 1'b0, 1'b0);
        push_d(64'hA2, 1'b0, 1'b1);
        push_d(64'hA3, 1'b1, 1'b0);
        exp_r(4'd5, 64'hA0, RESP_OKAY, 1'b0);
        exp_r(4'd5, 64'hA1, RESP_OKAY, 1'b0);
        exp_r(4'd5, 64'hA2, RESP_SLVERR, 1'b0);
        exp_r(4'd5, 64'hA3, RESP_DECERR, 1'b1);
        push_ar(4'd5, 32'h8000_0100, 8'd3, 3'd3, BURST_INCR);
        wait_idle("t2_burst");
        r_toggle = 1'b0;
        chk_mirror = 1'b0;
        @(posedge clk_i);
        #2 AXI_R_ready_i = 1'b1;
      end
      3: begin
        exp_a(PUT_PARTIAL_DATA, 8'd0, 32'h8000_0004, 8'hf0, 64'hDEADBEEF_00000000);
        push_w(64'hDEADBEEF_00000000, 8'hf0, 1'b1);
        push_d(64'd0, 1'b0, 1'b0);
        exp_b(4'd1, RESP_OKAY);
        push_aw(4'd1, 32'h8000_0004, 8'd0, 3'd2, BURST_INCR);
        wait_idle("t3_partial");
        exp_a(PUT_FULL_DATA, 8'd0, 32'h8000_0008, 8'hff, 64'h0123456789ABCDEF);
        push_w(64'h0123456789ABCDEF, 8'hff, 1'b1);
        push_d(64'd0, 1'b0, 1'b0);
        exp_b(4'd2, RESP_OKAY);
        push_aw(4'd2, 32'h8000_0008, 8'd0, 3'd3, BURST_INCR);
        wait_idle("t3_full");
        exp_a(PUT_FULL_DATA, 8'd0, 32'h8000_0008, 8'hff, 64'h5555AAAA5555AAAA);
        push_w(64'h5555AAAA5555AAAA, 8'hff, 1'b1);
        push_d(64'd0, 1'b1, 1'b0);
        exp_b(4'd2, RESP_DECERR);
        push_aw(4'd2, 32'h8000_0008, 8'd0, 3'd3, BURST_INCR);
        wait_idle("t3_denied");
      end
      4: begin
        // From reset the read wins; the flag then toggles on every grant.
        exp_a(GET, 8'd0, 32'h0000_0100, 8'hff, 64'd0);
        exp_a(PUT_FULL_DATA, 8'd0, 32'h0000_0200, 8'hff, 64'h77);
        push_d(64'h66, 1'b0, 1'b0);
        push_d(64'd0, 1'b0, 1'b0);
        exp_r(4'd6, 64'h66, RESP_OKAY, 1'b1);
        exp_b(4'd7, RESP_OKAY);
        push_w(64'h77, 8'hff, 1'b1);
        push_ar(4'd6, 32'h0000_0100, 8'd0, 3'd3, BURST_INCR);
        push_aw(4'd7, 32'h0000_0200, 8'd0, 3'd3, BURST_INCR);
        wait_idle("t4_pair1");
        exp_a(GET, 8'd0, 32'h0000_0300, 8'hff, 64'd0);
        push_d(64'h88, 1'b0, 1'b0);
        exp_r(4'd8, 64'h88, RESP_OKAY, 1'b1);
        push_ar(4'd8, 32'h0000_0300, 8'd0, 3'd3, BURST_INCR);
        wait_idle("t4_single");
        exp_a(PUT_FULL_DATA, 8'd0, 32'h0000_0400, 8'hff, 64'h99);
        exp_a(GET, 8'd0, 32'h0000_0500, 8'hff, 64'd0);
        push_d(64'd0, 1'b0, 1'b0);
        push_d(64'hAA, 1'b0, 1'b0);
        exp_b(4'd9, RESP_OKAY);
        exp_r(4'd10, 64'hAA, RESP_OKAY, 1'b1);
        push_w(64'h99, 8'hff, 1'b1);
        push_ar(4'd10, 32'h0000_0500, 8'd0, 3'd3, BURST_INCR);
        push_aw(4'd9, 32'h0000_0400, 8'd0, 3'd3, BURST_INCR);
        wait_idle("t4_pair2");
      end
      5: begin
        push_w(64'h1, 8'hff, 1'b0);
        push_w(64'h2, 8'hff, 1'b1);
        exp_b(4'd1, RESP_SLVERR);
        push_aw(4'd1, 32'h0000_1000, 8'd1, 3'd3, BURST_WRAP);
        wait_idle("t5_wrap");
        for (int i = 0; i < 32; i++) exp_r(4'd2, 64'd0, RESP_SLVERR, (i == 31));
        push_ar(4'd2, 32'h0000_2000, 8'd31, 3'd3, BURST_INCR);
        wait_idle("t5_long_read");
      end
      6: begin
        exp_a(PUT_PARTIAL_DATA, 8'd1, 32'h0000_3000, 8'hff, 64'hB0);
        exp_a(PUT_PARTIAL_DATA, 8'd1, 32'h0000_3000, 8'hff, 64'hB1);
        push_w(64'hB0, 8'hff, 1'b1);
        push_w(64'hB1, 8'hff, 1'b0);
        push_d(64'd0, 1'b0, 1'b0);
        exp_b(4'd3, RESP_SLVERR);
        push_aw(4'd3, 32'h0000_3000, 8'd1, 3'd3, BURST_INCR);
        wait_idle("t6_early_last");
      end
      default: ;
    endcase
  endtask

  task automatic reset_mid_read();
    logic seen;
    seen = 1'b0;
    @(posedge clk_i);
    #2 AXI_R_ready_i = 1'b0;
    exp_a(GET, 8'd3, 32'h0000_4000, 8'hff, 64'd0);
    for (int i = 0; i < 4; i++) push_d(64'hC0 + 64'(i), 1'b0, 1'b0);
    push_ar(4'd11, 32'h0000_4000, 8'd3, 3'd3, BURST_INCR);
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk_i);
      seen = AXI_R_valid_o;
    end
    checkOutput("t6_reached_rd_d", seen, 1'b1);
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    ar_q.delete(); d_q.delete(); exp_a_q.delete(); exp_r_q.delete();
    #1 checkOutput("t6_reset_valids", {AXI_R_valid_o, TL_A_valid_o, TL_D_ready_o, AXI_B_valid_o, AXI_AR_ready_o},
                   64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    AXI_R_ready_i = 1'b1;
    @(negedge clk_i);
    exp_a(GET, 8'd0, 32'h0000_5000, 8'hff, 64'd0);
    push_d(64'hD00D, 1'b0, 1'b0);
    exp_r(4'd12, 64'hD00D, RESP_OKAY, 1'b1);
    push_ar(4'd12, 32'h0000_5000, 8'd0, 3'd3, BURST_INCR);
    wait_idle("t6_after_reset");
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    $display("[TB] start");
    do_reset();
    applyStimulus(1);
    applyStimulus(2);
    applyStimulus(3);
    do_reset();
    applyStimulus(4);
    applyStimulus(5);
    applyStimulus(6);
    reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
